// File: rtl/cjb_nbit_arbmux_v_pkg.sv
// Shared definitions for the n-bit arbitrated multiplexer: mode encodings and
// the helper that derives the select width from the channel count.
package cjb_nbit_arbmux_v_pkg;

    localparam logic CJB_MODE_FIXED = 1'b0;
    localparam logic CJB_MODE_RR    = 1'b1;

    function automatic int cjb_sel_width(input int cnt);
        if (cnt <= 2) begin
            return 1;
        end else begin
            return $clog2(cnt);
        end
    endfunction

endpackage

// File: rtl/cjb_nbit_arbmux_v_rr.sv
// Combinational round-robin picker: rotate requests so ptr is bit 0, take the
// lowest set bit, rotate the one-hot result back into channel order.
module cjb_rr_arbiter_v
    import cjb_nbit_arbmux_v_pkg::*;
#(
    parameter int m  = 4,
    parameter int pw = cjb_sel_width(m)
) (
    input  logic [m-1:0]  req,
    input  logic [pw-1:0] ptr,
    input  logic          en,
    output logic [m-1:0]  gnt
);

    logic [2*m-1:0] rot_dbl_s;
    logic [2*m-1:0] back_dbl_s;
    logic [m-1:0]   rot_s;
    logic [m-1:0]   pick_s;
    logic           found_s;

    // Rotate requests right by ptr (ptr is always < m, so the doubled vector wraps modulo m)
    always_comb begin
        rot_dbl_s = {req, req} >> ptr;
        rot_s     = rot_dbl_s[m-1:0];
    end

    // Lowest-set-bit priority on the rotated requests
    always_comb begin
        pick_s  = {m{1'b0}};
        found_s = 1'b0;
        for (int i = 0; i < m; i++) begin
            if (rot_s[i] && !found_s) begin
                pick_s[i] = 1'b1;
                found_s   = 1'b1;
            end else begin
                pick_s[i] = 1'b0;
            end
        end
    end

    // Rotate the pick back into channel order and qualify with enable
    always_comb begin
        back_dbl_s = {pick_s, pick_s} << ptr;
        gnt        = back_dbl_s[2*m-1:m] & {m{en}};
    end

endmodule

// File: rtl/cjb_nbit_arbmux_v.sv
// Registered m-to-1 n-bit multiplexer with fixed-select or round-robin grant
// and a one-entry valid/ready output register.
module cjb_nbit_arbmux_v
    import cjb_nbit_arbmux_v_pkg::*;
#(
    parameter int n  = 8,
    parameter int m  = 4,
    parameter int sw = cjb_sel_width(m)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mode,
    input  logic [sw-1:0]   s,
    input  logic [m*n-1:0]  d,
    input  logic [m-1:0]    req,
    output logic [m-1:0]    gnt,
    output logic [n-1:0]    f,
    output logic            f_valid,
    output logic [sw-1:0]   f_sel,
    input  logic            f_ready
);

    logic [sw-1:0] ptr_r;
    logic          load_s;
    logic          en_s;
    logic [m-1:0]  rr_gnt_s;
    logic [m-1:0]  fix_gnt_s;
    logic          xfer_s;
    logic [sw-1:0] win_s;
    logic [n-1:0]  data_s;
    logic [sw-1:0] ptr_nxt_s;

    cjb_rr_arbiter_v #(
        .m  (m),
        .pw (sw)
    ) u_rr (
        .req (req),
        .ptr (ptr_r),
        .en  (en_s),
        .gnt (rr_gnt_s)
    );

    // Load enable; no grant may be issued while reset is asserted
    always_comb begin
        load_s = ~f_valid | f_ready;
        en_s   = load_s & ~reset;
    end

    // Fixed-select grant and the mode mux; s >= m matches no channel
    always_comb begin
        fix_gnt_s = {m{1'b0}};
        for (int i = 0; i < m; i++) begin
            fix_gnt_s[i] = en_s & req[i] & (s == sw'(i));
        end
        case (mode)
            CJB_MODE_RR:    gnt = rr_gnt_s;
            CJB_MODE_FIXED: gnt = fix_gnt_s;
            default:        gnt = {m{1'b0}};
        endcase
    end

    // One-hot AND-OR data select and winner index encode
    always_comb begin
        data_s = {n{1'b0}};
        win_s  = {sw{1'b0}};
        for (int i = 0; i < m; i++) begin
            data_s = data_s | (d[i*n +: n] & {n{gnt[i]}});
            win_s  = win_s | (sw'(i) & {sw{gnt[i]}});
        end
        xfer_s = |(req & gnt);
        if (win_s == sw'(m - 1)) begin
            ptr_nxt_s = {sw{1'b0}};
        end else begin
            ptr_nxt_s = win_s + {{(sw-1){1'b0}}, 1'b1};
        end
    end

    // Output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            f       <= {n{1'b0}};
            f_valid <= 1'b0;
            f_sel   <= {sw{1'b0}};
            ptr_r   <= {sw{1'b0}};
        end else if (xfer_s) begin
            f       <= data_s;
            f_sel   <= win_s;
            f_valid <= 1'b1;
            if (mode == CJB_MODE_RR) begin
                ptr_r <= ptr_nxt_s;
            end else begin
                ptr_r <= ptr_r;
            end
        end else if (f_valid && f_ready) begin
            f_valid <= 1'b0;
        end else begin
            f_valid <= f_valid;
        end
    end

endmodule

// File: tb/tb_cjb_nbit_arbmux_v.sv
// Directed self-checking bench for cjb_nbit_arbmux_v (m=4 main instance, m=3
// instance for modulo wrap of the round-robin pointer).
module tb_cjb_nbit_arbmux_v;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic [1:0]  s;
    logic [31:0] d;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [7:0]  f;
    logic        f_valid;
    logic [1:0]  f_sel;
    logic        f_ready;

    logic        mode3;
    logic [1:0]  s3;
    logic [23:0] d3;
    logic [2:0]  req3;
    logic [2:0]  gnt3;
    logic [7:0]  f3;
    logic        f_valid3;
    logic [1:0]  f_sel3;
    logic        f_ready3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cjb_nbit_arbmux_v #(.n(8), .m(4), .sw(2)) dut (
        .clk(clk), .reset(reset), .mode(mode), .s(s), .d(d), .req(req),
        .gnt(gnt), .f(f), .f_valid(f_valid), .f_sel(f_sel), .f_ready(f_ready)
    );

    cjb_nbit_arbmux_v #(.n(8), .m(3), .sw(2)) dut3 (
        .clk(clk), .reset(reset), .mode(mode3), .s(s3), .d(d3), .req(req3),
        .gnt(gnt3), .f(f3), .f_valid(f_valid3), .f_sel(f_sel3), .f_ready(f_ready3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] rr_exp [5];
        rr_exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};

        reset    = 1'b1;
        mode     = 1'b1;
        s        = 2'd0;
        d        = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req      = 4'b1111;
        f_ready  = 1'b1;
        mode3    = 1'b1;
        s3       = 2'd0;
        d3       = {8'hA2, 8'hA1, 8'hA0};
        req3     = 3'b000;
        f_ready3 = 1'b1;

        // Reset held with all requests active
        tick;
        chk("rst_gnt_a", {28'd0, gnt}, 32'h0);
        tick;
        chk("rst_gnt", {28'd0, gnt}, 32'h0);
        chk("rst_f_valid", {31'd0, f_valid}, 32'h0);
        chk("rst_f", {24'd0, f}, 32'h0);
        chk("rst_f_sel", {30'd0, f_sel}, 32'h0);
        chk("rst_gnt3", {29'd0, gnt3}, 32'h0);

        // Round-robin fairness, all requests held
        reset = 1'b0;
        #1;
        chk("rr_first_gnt", {28'd0, gnt}, 32'h1);
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("rr_f", {24'd0, f}, {24'd0, rr_exp[k]});
            chk("rr_f_valid", {31'd0, f_valid}, 32'h1);
            chk("rr_f_sel", {30'd0, f_sel}, k % 4);
        end

        // Sparse requests, ptr now 1: grants 3, 0, 3
        req = 4'b1001;
        #1;
        chk("sp_gnt0", {28'd0, gnt}, 32'h8);
        tick;
        chk("sp_f0", {24'd0, f}, 32'hA3);
        chk("sp_sel0", {30'd0, f_sel}, 32'h3);
        chk("sp_gnt1", {28'd0, gnt}, 32'h1);
        tick;
        chk("sp_f1", {24'd0, f}, 32'hA0);
        chk("sp_sel1", {30'd0, f_sel}, 32'h0);
        chk("sp_gnt2", {28'd0, gnt}, 32'h8);
        tick;
        chk("sp_f2", {24'd0, f}, 32'hA3);
        chk("sp_sel2", {30'd0, f_sel}, 32'h3);

        // Fixed mode select 2, then select of an idle channel
        mode = 1'b0;
        s    = 2'd2;
        req  = 4'b0110;
        d[23:16] = 8'h5C;
        #1;
        chk("fx_gnt", {28'd0, gnt}, 32'h4);
        tick;
        chk("fx_f", {24'd0, f}, 32'h5C);
        chk("fx_sel", {30'd0, f_sel}, 32'h2);
        chk("fx_valid", {31'd0, f_valid}, 32'h1);
        s = 2'd3;
        #1;
        chk("fx_idle_gnt", {28'd0, gnt}, 32'h0);
        tick;
        chk("fx_drop_valid", {31'd0, f_valid}, 32'h0);
        chk("fx_hold_f", {24'd0, f}, 32'h5C);
        chk("fx_hold_sel", {30'd0, f_sel}, 32'h2);

        // Back-pressure in round-robin mode (ptr is 0 after the sparse phase)
        mode = 1'b1;
        req  = 4'b1111;
        f_ready = 1'b0;
        d[23:16] = 8'hA2;
        #1;
        chk("bp_load_gnt", {28'd0, gnt}, 32'h1);
        tick;
        chk("bp_f0", {24'd0, f}, 32'hA0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_gnt", {28'd0, gnt}, 32'h0);
            tick;
            chk("bp_f", {24'd0, f}, 32'hA0);
            chk("bp_valid", {31'd0, f_valid}, 32'h1);
            chk("bp_sel", {30'd0, f_sel}, 32'h0);
        end
        f_ready = 1'b1;
        #1;
        chk("bp_release_gnt", {28'd0, gnt}, 32'h2);
        tick;
        chk("bp_b2b_f", {24'd0, f}, 32'hA1);
        chk("bp_b2b_valid", {31'd0, f_valid}, 32'h1);
        chk("bp_b2b_sel", {30'd0, f_sel}, 32'h1);

        // Reset while a word is held under back-pressure
        f_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("mr_gnt", {28'd0, gnt}, 32'h0);
        tick;
        chk("mr_valid", {31'd0, f_valid}, 32'h0);
        chk("mr_f", {24'd0, f}, 32'h0);
        reset = 1'b0;
        #1;
        chk("mr_ptr0_gnt", {28'd0, gnt}, 32'h1);
        tick;
        chk("mr_next_f", {24'd0, f}, 32'hA0);
        chk("mr_next_sel", {30'd0, f_sel}, 32'h0);

        // m=3 instance: f_sel cycles 0,1,2 only
        req3 = 3'b111;
        for (int k = 0; k < 6; k++) begin
            tick;
            chk("m3_sel", {30'd0, f_sel3}, k % 3);
            chk("m3_f", {24'd0, f3}, 32'hA0 + (k % 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
